// File: rtl/fpadd_pkg.sv
// Shared types and constants for the FP32 adder issue controller.
// Perf counters in the top are enabled by defining FPADD_ISSUE_PERF_EN.
package fpadd_pkg;

    localparam int FP32_W    = 32;
    localparam int FPADD_LAT = 3;

    typedef logic [FP32_W-1:0] fp32_t;

    typedef struct packed {
        fp32_t a;
        fp32_t b;
    } fp_pair_t;

endpackage

// File: rtl/fpadd_sync_fifo.sv
// Synchronous FIFO with a separate occupancy count.
// The head reads as zero while the FIFO is empty.
module fpadd_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == FULL_CNT;
    assign empty_o = cnt_q == '0;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        cnt_d = cnt_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

endmodule

// File: rtl/fpadd_issue_ctrl.sv
// Credit-gated issue controller for a fixed-latency FP32 adder.
// Optional issue/stall counters: define FPADD_ISSUE_PERF_EN.
module fpadd_issue_ctrl
    import fpadd_pkg::*;
#(
    parameter int OP_DEPTH  = 4,
    parameter int RES_DEPTH = 4,
    parameter int LAT       = FPADD_LAT
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    output logic  in_ready,
    input  fp32_t in_a,
    input  fp32_t in_b,
    output fp32_t add_a,
    output fp32_t add_b,
    input  fp32_t add_out,
    output logic  res_valid,
    input  logic  res_ready,
    output fp32_t res_data
`ifdef FPADD_ISSUE_PERF_EN
    ,
    output logic [31:0] issue_cnt,
    output logic [31:0] stall_cnt
`endif
);
    localparam int RW = $clog2(RES_DEPTH) + 1;
    localparam logic [RW-1:0] RES_MAX = RW'(RES_DEPTH);

    fp_pair_t        op_head;
    logic            op_full, op_empty;
    logic            res_full, res_empty;
    logic            issue, credit, res_pop;
    logic [LAT-1:0]  inflight_q, inflight_d;
    logic [RW-1:0]   reserved_q, reserved_d;

    assign in_ready  = !op_full;
    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;
    // Credit covers queued results plus everything still in the adder.
    assign credit    = reserved_q < RES_MAX;
    assign issue     = !op_empty && credit && !res_full;
    assign add_a     = issue ? op_head.a : '0;
    assign add_b     = issue ? op_head.b : '0;

    fpadd_sync_fifo #(
        .WIDTH ($bits(fp_pair_t)),
        .DEPTH (OP_DEPTH)
    ) u_op_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (in_valid),
        .din_i   ({in_a, in_b}),
        .pop_i   (issue),
        .dout_o  (op_head),
        .full_o  (op_full),
        .empty_o (op_empty)
    );

    fpadd_sync_fifo #(
        .WIDTH (FP32_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q[LAT-1]),
        .din_i   (add_out),
        .pop_i   (res_pop),
        .dout_o  (res_data),
        .full_o  (res_full),
        .empty_o (res_empty)
    );

    if (LAT == 1) begin : g_lat1
        assign inflight_d = issue;
    end else begin : g_latn
        assign inflight_d = {inflight_q[LAT-2:0], issue};
    end

    always_comb begin
        reserved_d = reserved_q;
        unique case ({issue, res_pop})
            2'b10:   reserved_d = reserved_q + 1'b1;
            2'b01:   reserved_d = reserved_q - 1'b1;
            default: reserved_d = reserved_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
            reserved_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            reserved_q <= reserved_d;
        end
    end

`ifdef FPADD_ISSUE_PERF_EN
    logic [31:0] issue_cnt_q, stall_cnt_q;

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_q + 32'(issue);
            stall_cnt_q <= stall_cnt_q + 32'(!op_empty && !issue);
        end
    end
`endif

endmodule

// File: tb/tb_fpadd_issue_ctrl.sv
// Bench for fpadd_issue_ctrl: queue-based reference model plus directed cases.
// Perf counter checks are included when FPADD_ISSUE_PERF_EN is defined.
module tb_fpadd_issue_ctrl;
    localparam int OPD  = 4;
    localparam int RESD = 4;
    localparam int LAT  = 3;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } pr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] in_a, in_b;
    logic [31:0] add_a, add_b, add_out;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic [31:0] issue_cnt, stall_cnt;

    always #5 clk = ~clk;

    fpadd_issue_ctrl #(
        .OP_DEPTH  (OPD),
        .RES_DEPTH (RESD),
        .LAT       (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_out   (add_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data)
`ifdef FPADD_ISSUE_PERF_EN
        ,
        .issue_cnt (issue_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

`ifndef FPADD_ISSUE_PERF_EN
    assign issue_cnt = '0;
    assign stall_cnt = '0;
`endif

    // Stand-in adder: bit-level mix, except the one FP case used directly.
    function automatic logic [31:0] fadd(input logic [31:0] a,
                                         input logic [31:0] b);
        if (a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A0000;
    endfunction

    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fadd(add_a, add_b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign add_out = pipe[LAT-1];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: operand queue, in-flight results with countdown,
    // result queue, and perf counters.
    pr_t         opq [$];
    logic [31:0] resq [$];
    int          fl_cnt [$];
    logic [31:0] fl_v [$];
    logic [31:0] m_iss, m_stall;
    bit          started = 0;

    function automatic bit m_issue();
        return opq.size() > 0 && (resq.size() + fl_v.size()) < RESD;
    endfunction

    always @(posedge clk) begin
        bit  iss, acc, pop;
        pr_t p;
        if (reset) begin
            opq.delete();
            resq.delete();
            fl_cnt.delete();
            fl_v.delete();
            m_iss   = 0;
            m_stall = 0;
            started = 1;
        end else if (started) begin
            iss = m_issue();
            acc = in_valid && opq.size() < OPD;
            pop = resq.size() > 0 && res_ready;
            if (iss) m_iss = m_iss + 1;
            if (opq.size() > 0 && !iss) m_stall = m_stall + 1;
            if (pop) void'(resq.pop_front());
            for (int i = 0; i < fl_cnt.size(); i++) fl_cnt[i]--;
            while (fl_cnt.size() > 0 && fl_cnt[0] == 0) begin
                resq.push_back(fl_v[0]);
                void'(fl_cnt.pop_front());
                void'(fl_v.pop_front());
            end
            if (iss) begin
                p = opq.pop_front();
                fl_cnt.push_back(LAT);
                fl_v.push_back(fadd(p.a, p.b));
            end
            if (acc) opq.push_back({in_a, in_b});
        end
    end

    always @(negedge clk) begin
        bit          iss;
        logic [31:0] ea, eb, ed;
        if (started) begin
            iss = m_issue();
            ea  = iss ? opq[0].a : 32'h0;
            eb  = iss ? opq[0].b : 32'h0;
            ed  = resq.size() > 0 ? resq[0] : 32'h0;
            chk("in_ready", 32'(in_ready), 32'(opq.size() < OPD));
            chk("add_a", add_a, ea);
            chk("add_b", add_b, eb);
            chk("res_valid", 32'(res_valid), 32'(resq.size() > 0));
            chk("res_data", res_data, ed);
`ifdef FPADD_ISSUE_PERF_EN
            chk("issue_cnt", issue_cnt, m_iss);
            chk("stall_cnt", stall_cnt, m_stall);
`endif
        end
    end

    int acc, pops, iss_seen;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        if (in_valid && in_ready) acc++;
        if (res_valid && res_ready) pops++;
        if (add_a != 32'h0) iss_seen++;
        step();
    endtask

    task automatic clr();
        acc = 0;
        pops = 0;
        iss_seen = 0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 40; i++) cyc();
        chk("drain_empty", 32'(res_valid), 32'h0);
    endtask

    function automatic logic [31:0] rw();
        return $urandom() | 32'h1;
    endfunction

    initial begin
        int          rv, first, full_seen;
        logic [31:0] st0;
        reset = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_add_a", add_a, 32'h0);
        chk("rst_add_b", add_b, 32'h0);

        // Single pair
        reset = 1'b0;
        in_valid = 1'b1;
        in_a = 32'h3F800000;
        in_b = 32'h40000000;
        step();
        in_valid = 1'b0;
        chk("t1_add_a", add_a, 32'h3F800000);
        chk("t1_add_b", add_b, 32'h40000000);
        rv = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (res_valid && rv == 0) rv = k;
        end
        chk("t1_latency", 32'(rv), 32'd4);
        chk("t1_data", res_data, 32'h40400000);
        drain();

        // Streaming 16 pairs
        clr();
        first = -1;
        res_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            in_valid = acc < 16;
            in_a = rw();
            in_b = rw();
            if (res_valid && res_ready && first < 0) first = k;
            cyc();
        end
        chk("t2_pops", 32'(pops), 32'd16);
        chk("t2_first_pop", 32'(first), 32'd5);
        drain();

        // Backpressure: 10 pairs offered, res_ready low
        clr();
        st0 = stall_cnt;
        res_ready = 1'b0;
        for (int k = 0; k < 30; k++) begin
            in_valid = 1'b1;
            in_a = rw();
            in_b = rw();
            cyc();
        end
        chk("t3_accepted", 32'(acc), 32'd8);
        chk("t3_issued", 32'(iss_seen), 32'd4);
        chk("t3_in_ready", 32'(in_ready), 32'h0);
`ifdef FPADD_ISSUE_PERF_EN
        chk("t3_stall_grew", 32'(stall_cnt > st0), 32'h1);
`endif
        res_ready = 1'b1;
        for (int k = 0; k < 60; k++) begin
            in_valid = acc < 10;
            in_a = rw();
            in_b = rw();
            cyc();
        end
        chk("t3_drained", 32'(pops), 32'd10);
        drain();

        // Reset with 2 in flight and 3 queued
        clr();
        res_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = acc < 6;
            in_a = rw();
            in_b = rw();
            cyc();
        end
        chk("t4_resq_pre", 32'(resq.size()), 32'd4);
        chk("t4_opq_pre", 32'(opq.size()), 32'd2);
        res_ready = 1'b1;
        in_valid = 1'b1;
        in_a = rw();
        step();
        in_a = rw();
        step();
        res_ready = 1'b0;
        in_a = rw();
        step();
        in_valid = 1'b0;
        chk("t4_inflight", 32'(fl_v.size()), 32'd2);
        chk("t4_queued", 32'(opq.size()), 32'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_res_valid", 32'(res_valid), 32'h0);
        chk("t4_in_ready", 32'(in_ready), 32'h1);
        res_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t4_no_late", 32'(res_valid), 32'h0);
        end

        // Full operand FIFO with res_ready toggling
        clr();
        full_seen = 0;
        for (int k = 0; k < 60; k++) begin
            in_valid = 1'b1;
            res_ready = k[0];
            in_a = rw();
            in_b = rw();
            if (!in_ready) full_seen++;
            cyc();
        end
        drain();
        chk("t5_full_seen", 32'(full_seen > 0), 32'h1);
        chk("t5_no_loss", 32'(pops), 32'(acc));

        // Random traffic with one mid-run reset
        for (int k = 0; k < 400; k++) begin
            in_valid = $urandom_range(0, 3) != 0;
            res_ready = $urandom_range(0, 1) == 1;
            in_a = rw();
            in_b = rw();
            reset = k == 200;
            step();
        end
        reset = 1'b0;
        clr();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpadd_issue_ctrl.md
FPADD_ISSUE_CTRL -- requirements
Module: fpadd_issue_ctrl

Interface
REQ-001 Parameter OP_DEPTH, default 4: operand FIFO entries, power of two, at least 2.
REQ-002 Parameter RES_DEPTH, default 4: result FIFO entries, power of two, at least 2.
REQ-003 Parameter LAT, default 3: clock edges from the adder sampling reg_A/reg_B to its out register holding the sum.
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  an operand pair is offered.
REQ-007 in_ready  out  1  the operand FIFO can accept a pair.
REQ-008 in_a, in_b  in  32 each  FP32 operands.
REQ-009 add_a, add_b  out  32 each  drive the adder's reg_A and reg_B.
REQ-010 add_out  in  32  the adder's out.
REQ-011 res_valid  out  1  the result FIFO head is valid.
REQ-012 res_ready  in  1  the consumer accepts the head.
REQ-013 res_data  out  32  the result FIFO head.

Function
REQ-014 Accept a pair at edge E when in_valid and in_ready are both high; in_ready = operand FIFO not full, registered, with no combinational path from res_ready.
REQ-015 Issue happens in a cycle when the operand FIFO is not empty and reserved < RES_DEPTH.
- reserved counts result FIFO occupancy plus results in flight.
- In an issue cycle, add_a/add_b = operand FIFO head, and the head is popped at the next edge.
- In every other cycle, add_a/add_b = 32'h0.
REQ-016 An in-flight shift register, LAT bits wide:
- bit0 is loaded with the issue flag at each edge;
- bits shift by one per edge;
- when bit[LAT-1] is 1, add_out is written into the result FIFO at the next edge.
REQ-017 reserved update at each edge:
- +1 on issue, -1 on result pop, unchanged when both occur;
- a pop in the same cycle does not enable an issue (no combinational credit return).
REQ-018 The result FIFO never overflows, because issue is credit-gated; res_valid = result FIFO not empty.
REQ-019 A pop happens at an edge where res_valid and res_ready are both high; res_data must be stable while res_valid is high and res_ready is low.
REQ-020 Latency, for a pair accepted at edge E into empty FIFOs with credit available:
- issued in the cycle after E;
- written into the result FIFO at edge E+1+LAT;
- res_valid high from edge E+1+LAT onward.
REQ-021 Ordering: results leave in strict acceptance order; throughput is one pair per cycle when not backpressured.
REQ-022 Boundary conditions:
- Push into a full operand FIFO is blocked.
- Push and pop of the operand FIFO at the same edge are both performed, and occupancy is unchanged.
- Write and read of the result FIFO at the same edge are both performed.
- Pointers wrap modulo depth, with a separate count register distinguishing full from empty.
REQ-023 No arithmetic is performed on operands; values pass bit-exact to the adder and from add_out.

Reset
REQ-024 While reset is high at an edge, the following are cleared to 0: both FIFO pointers and counts, the in-flight register, and reserved.
REQ-025 Output values after reset:
- in_ready = 1 from the first edge with reset high;
- res_valid = 0, res_data = 32'h0;
- add_a = add_b = 32'h0.
REQ-026 Reset mid-operation discards queued operands and all in-flight results; add_out values arriving after reset are ignored.

Configuration
REQ-027 Macro FPADD_ISSUE_PERF_EN, when defined, adds two ports:
- issue_cnt  out  32: increments on each issue;
- stall_cnt  out  32: increments each cycle the operand FIFO is not empty but credit is exhausted.
- Both counters wrap modulo 2^32 and are cleared by reset.
REQ-028 Without FPADD_ISSUE_PERF_EN, neither port nor any counter logic exists.

Structure
REQ-029 Package fpadd_pkg holds:
- typedef fp32_t (32-bit vector);
- constants FP32_W=32 and FPADD_LAT=3;
- LAT defaults to FPADD_LAT.
REQ-030 Both FIFOs are instances of one sub-module, fpadd_sync_fifo (parameters WIDTH, DEPTH), with synchronous reset.

Verification
REQ-031 Single pair: a=3F800000, b=40000000 accepted at edge 0, with the model adder returning 40400000:
- add_a/add_b visible in cycle 1;
- res_valid rises at edge 4;
- res_data = 40400000.
REQ-032 Streaming 16 pairs with in_valid and res_ready held high: one result per cycle after the initial 4-cycle latency, in order.
REQ-033 res_ready held low while 10 pairs are offered:
- exactly RES_DEPTH=4 issues occur;
- the operand FIFO fills and in_ready drops after 8 accepted (4 issued + 4 queued);
- stall_cnt increments when the macro is defined;
- releasing res_ready drains all 10 in order.
REQ-034 Reset asserted for one edge with 2 results in flight and 3 queued:
- afterwards res_valid=0 and in_ready=1;
- the late add_out values are not captured.
REQ-035 Simultaneous push and pop on a full operand FIFO with res_ready toggling every cycle: occupancy is preserved and no result is lost or duplicated.
